// File: rtl/dmem_subword_ctrl.sv
// Data-memory controller: valid/ready request port, wait states, RV32I sub-word access.
// Define DMEM_SUBWORD_EN for byte/halfword support; otherwise every access is word-only.
module dmem_subword_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  generate
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
      $error("dmem_subword_ctrl: WAIT_STATES must be 0..15");
    end
  endgenerate

  logic [31:0]   mem [DEPTH_WORDS];
  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          accept;
  logic          oor;
  logic          err;
  logic [AW-1:0] idx;
  logic [31:0]   word;
  logic [31:0]   ld;
  logic [31:0]   wd;
  logic [3:0]    be;

  assign req_ready  = (state == S_IDLE) && !rst;
  assign resp_valid = (state == S_RESP);
  assign accept     = req_valid && req_ready;
  assign idx        = req_addr[AW+1:2];
  assign oor        = {2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS);
  assign word       = mem[idx];

`ifdef DMEM_SUBWORD_EN
  logic        misal;
  logic        bad_op;
  logic [15:0] sel;

  // One shifter serves both byte and halfword lanes.
  assign sel = 16'(word >> {req_addr[1:0], 3'b000});

  always_comb begin
    misal  = 1'b0;
    bad_op = 1'b0;
    be     = 4'b0000;
    wd     = req_wdata;
    ld     = word;
    case (req_funct3)
      3'd0, 3'd4: begin
        be     = 4'b0001 << req_addr[1:0];
        wd     = {4{req_wdata[7:0]}};
        ld     = req_funct3[2] ? {24'd0, sel[7:0]}
                               : {{24{sel[7]}}, sel[7:0]};
        bad_op = req_we && req_funct3[2];
      end
      3'd1, 3'd5: begin
        misal  = req_addr[0];
        be     = req_addr[1] ? 4'b1100 : 4'b0011;
        wd     = {2{req_wdata[15:0]}};
        ld     = req_funct3[2] ? {16'd0, sel}
                               : {{16{sel[15]}}, sel};
        bad_op = req_we && req_funct3[2];
      end
      3'd2: begin
        misal = |req_addr[1:0];
        be    = 4'b1111;
      end
      default: bad_op = 1'b1;
    endcase
  end

  assign err = oor || misal || bad_op;
`else
  logic unused_funct3;

  assign unused_funct3 = ^req_funct3;
  assign be  = 4'b1111;
  assign wd  = req_wdata;
  assign ld  = word;
  assign err = oor || (req_addr[1:0] != 2'b00);
`endif

  // Stores commit on the acceptance edge, independent of the response path.
  always_ff @(posedge clk) begin
    if (accept && req_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wd[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            resp_rdata <= (req_we || err) ? 32'd0 : ld;
            resp_err   <= err;
            cnt        <= CNT_INIT;
            state      <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_RESP;
          else cnt <= cnt - 4'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_subword_ctrl.sv
// Bench for dmem_subword_ctrl: behavioural memory model, randomized and directed traffic.
// Two instances: WAIT_STATES=1 for the main traffic, WAIT_STATES=0 for back-to-back.
module tb_dmem_subword_ctrl;

  localparam int DEPTH = 64;
  localparam int WA    = 1;
  localparam int WZ    = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        a_valid = 1'b0;
  logic        a_ready;
  logic        a_we = 1'b0;
  logic [2:0]  a_f3 = 3'd0;
  logic [31:0] a_addr = 32'd0;
  logic [31:0] a_wdata = 32'd0;
  logic        a_rv;
  logic [31:0] a_rd;
  logic        a_err;

  logic        z_valid = 1'b0;
  logic        z_ready;
  logic        z_we = 1'b0;
  logic [2:0]  z_f3 = 3'd0;
  logic [31:0] z_addr = 32'd0;
  logic [31:0] z_wdata = 32'd0;
  logic        z_rv;
  logic [31:0] z_rd;
  logic        z_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          due;
  } exp_t;

  exp_t qa[$];
  exp_t qz[$];

  logic [31:0] mdl_a [DEPTH];
  logic [31:0] mdl_z [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_subword_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WA)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(a_valid), .req_ready(a_ready),
    .req_we(a_we), .req_funct3(a_f3),
    .req_addr(a_addr), .req_wdata(a_wdata),
    .resp_valid(a_rv), .resp_rdata(a_rd), .resp_err(a_err)
  );

  dmem_subword_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WZ)) u_z (
    .clk(clk), .rst(rst),
    .req_valid(z_valid), .req_ready(z_ready),
    .req_we(z_we), .req_funct3(z_f3),
    .req_addr(z_addr), .req_wdata(z_wdata),
    .resp_valid(z_rv), .resp_rdata(z_rd), .resp_err(z_err)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Access semantics from byte offset, access size and signedness.
  function automatic void model(
    input  logic        we,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [31:0] nword,
    output logic [31:0] rd,
    output logic        er
  );
    int          off;
    int          size;
    logic        sgn;
    logic [31:0] v;
    logic [31:0] mask;
    nword = word;
    rd    = 32'd0;
    off   = int'(addr % 4);
    er    = (addr / 4) >= DEPTH;
`ifdef DMEM_SUBWORD_EN
    size = 0;
    sgn  = 1'b0;
    if (we) begin
      if (f3 <= 3'd2) size = 1 << f3;
    end else begin
      case (f3)
        3'd0: begin size = 1; sgn = 1'b1; end
        3'd1: begin size = 2; sgn = 1'b1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: size = 0;
      endcase
    end
    if (size == 0 || (off % size) != 0) er = 1'b1;
    if (!er) begin
      if (we) begin
        for (int k = 0; k < size; k++)
          nword[(off + k)*8 +: 8] = wdata[k*8 +: 8];
      end else begin
        mask = (size == 4) ? 32'hFFFF_FFFF
                           : ((32'd1 << (8*size)) - 32'd1);
        v = (word >> (8*off)) & mask;
        if (sgn && size < 4 && v[8*size-1]) v = v | ~mask;
        rd = v;
      end
    end
`else
    size = 4;
    sgn  = 1'b0;
    v    = 32'd0;
    mask = 32'd0;
    if (off != 0) er = 1'b1;
    if (!er) begin
      if (we) nword = wdata;
      else rd = word;
    end
`endif
  endfunction

  task automatic apply(input logic which, input logic we,
                       input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int due);
    exp_t        e;
    logic [31:0] w;
    logic [31:0] nw;
    int          wi;
    wi = int'(addr / 4);
    w  = 32'd0;
    if (addr / 4 < DEPTH) w = which ? mdl_z[wi] : mdl_a[wi];
    model(we, f3, addr, wd, w, nw, e.rd, e.er);
    if (addr / 4 < DEPTH) begin
      if (which) mdl_z[wi] = nw;
      else mdl_a[wi] = nw;
    end
    e.due = due;
    if (which) qz.push_back(e);
    else qa.push_back(e);
  endtask

  task automatic do_a(input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd);
    int k;
    a_we = we;
    a_f3 = f3;
    a_addr = addr;
    a_wdata = wd;
    a_valid = 1'b1;
    for (k = 0; k < 50; k++) begin
      if (a_ready) break;
      @(negedge clk);
    end
    chk("a_ready_wait", a_ready, 1);
    if (a_ready) apply(1'b0, we, f3, addr, wd, cyc + 1 + WA);
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic wait_a(output logic [31:0] rd, output logic er,
                        output int lat);
    lat = 0;
    while (!a_rv && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("a_resp_wait", a_rv, 1);
    rd = a_rd;
    er = a_err;
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wd);
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_a(1'b1, f3, addr, wd);
    wait_a(rd, er, lat);
  endtask

  task automatic pin(input string name, input logic we,
                     input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [32:0] exp);
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_a(we, f3, addr, wd);
    wait_a(rd, er, lat);
    chk(name, {er, rd}, exp);
  endtask

  always @(negedge clk) begin : cmp
    exp_t e;
    if (a_rv) begin
      if (qa.size() == 0) begin
        chk("a_spurious_resp", a_rv, 0);
      end else begin
        e = qa.pop_front();
        chk("a_rdata", a_rd, e.rd);
        chk("a_err", a_err, e.er);
        chk("a_latency", cyc, e.due);
      end
    end else if (qa.size() != 0 && cyc > qa[0].due) begin
      chk("a_resp_missing", a_rv, 1);
      qa.delete(0);
    end
    if (z_rv) begin
      if (qz.size() == 0) begin
        chk("z_spurious_resp", z_rv, 0);
      end else begin
        e = qz.pop_front();
        chk("z_rdata", z_rd, e.rd);
        chk("z_err", z_err, e.er);
        chk("z_latency", cyc, e.due);
      end
    end else if (qz.size() != 0 && cyc > qz[0].due) begin
      chk("z_resp_missing", z_rv, 1);
      qz.delete(0);
    end
    if (a_rv && a_ready) chk("a_ready_overlap", a_ready, 0);
    if (z_rv && z_ready) chk("z_ready_overlap", z_ready, 0);
  end

  initial begin : main
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          k;
    int          acc;
    int          prev;
    int          w;
    logic [31:0] addr;

    for (int i = 0; i < DEPTH; i++) begin
      mdl_a[i] = 32'd0;
      mdl_z[i] = 32'd0;
    end

    repeat (3) @(negedge clk);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_z_ready", z_ready, 0);
    chk("rst_resp_valid", a_rv, 0);
    chk("rst_rdata", a_rd, 0);
    chk("rst_err", a_err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", a_ready, 1);

    for (int i = 0; i < 16; i++) st(3'd2, 32'(i*4), 32'd0);
    st(3'd2, 32'hFC, 32'd0);

    st(3'd2, 32'h0, 32'h4);
    do_a(1'b0, 3'd2, 32'h0, 32'd0);
    wait_a(rd, er, lat);
    chk("lw0_data", {er, rd}, {1'b0, 32'h4});
    chk("lw0_latency", lat, WA);

    st(3'd2, 32'h10, 32'h80FF7F01);
`ifdef DMEM_SUBWORD_EN
    pin("lb_10",  1'b0, 3'd0, 32'h10, 0, {1'b0, 32'h00000001});
    pin("lb_11",  1'b0, 3'd0, 32'h11, 0, {1'b0, 32'h0000007F});
    pin("lb_13",  1'b0, 3'd0, 32'h13, 0, {1'b0, 32'hFFFFFF80});
    pin("lbu_13", 1'b0, 3'd4, 32'h13, 0, {1'b0, 32'h00000080});
`else
    pin("lb_10",  1'b0, 3'd0, 32'h10, 0, {1'b0, 32'h80FF7F01});
    pin("lb_11",  1'b0, 3'd0, 32'h11, 0, {1'b1, 32'h0});
    pin("lb_13",  1'b0, 3'd0, 32'h13, 0, {1'b1, 32'h0});
    pin("lbu_13", 1'b0, 3'd4, 32'h13, 0, {1'b1, 32'h0});
`endif

    st(3'd2, 32'h10, 32'h11223344);
    st(3'd1, 32'h12, 32'h0000BEEF);
`ifdef DMEM_SUBWORD_EN
    pin("sh_lw_10", 1'b0, 3'd2, 32'h10, 0, {1'b0, 32'hBEEF3344});
    pin("lhu_12",   1'b0, 3'd5, 32'h12, 0, {1'b0, 32'h0000BEEF});
    pin("lh_12",    1'b0, 3'd1, 32'h12, 0, {1'b0, 32'hFFFFBEEF});
`else
    pin("sh_lw_10", 1'b0, 3'd2, 32'h10, 0, {1'b0, 32'h11223344});
    pin("lhu_12",   1'b0, 3'd5, 32'h12, 0, {1'b1, 32'h0});
    pin("lh_12",    1'b0, 3'd1, 32'h12, 0, {1'b1, 32'h0});
`endif

    pin("lh_01", 1'b0, 3'd1, 32'h01, 0, {1'b1, 32'h0});
    st(3'd2, 32'h04, 32'h55667788);
    pin("sw_06", 1'b1, 3'd2, 32'h06, 32'hDEADBEEF, {1'b1, 32'h0});
    pin("lw_04", 1'b0, 3'd2, 32'h04, 0, {1'b0, 32'h55667788});
    pin("lw_oor", 1'b0, 3'd2, 32'(DEPTH*4), 0, {1'b1, 32'h0});
    pin("sw_oor", 1'b1, 3'd2, 32'(DEPTH*4), 32'h1, {1'b1, 32'h0});
    pin("lw_last", 1'b0, 3'd2, 32'(DEPTH*4-4), 0, {1'b0, 32'h0});
`ifdef DMEM_SUBWORD_EN
    pin("ld_f3_3", 1'b0, 3'd3, 32'h0, 0, {1'b1, 32'h0});
`else
    pin("ld_f3_3", 1'b0, 3'd3, 32'h0, 0, {1'b0, 32'h4});
`endif

    for (int i = 0; i < 150; i++) begin
      k = int'($urandom_range(0, 9));
      if (k == 0) w = DEPTH + int'($urandom_range(0, 5));
      else if (k == 1) w = DEPTH - 1;
      else w = int'($urandom_range(0, 15));
      addr = 32'(w*4);
      if ($urandom_range(0, 3) == 0) addr = addr + 32'($urandom_range(1, 3));
      do_a(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           addr, $urandom);
    end

    st(3'd2, 32'h2C, 32'hA5A55A5A);
    do_a(1'b0, 3'd2, 32'h2C, 32'd0);
    rst = 1'b1;
    qa.delete();
    @(negedge clk);
    chk("midrst_ready", a_ready, 0);
    chk("midrst_no_resp", a_rv, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_back", a_ready, 1);
    chk("midrst_still_no_resp", a_rv, 0);
    pin("midrst_kept", 1'b0, 3'd2, 32'h2C, 0, {1'b0, 32'hA5A55A5A});

    z_valid = 1'b1;
    prev = 0;
    for (int i = 0; i < 24; i++) begin
      if (i < 8) begin
        z_we = 1'b1;
        z_f3 = 3'd2;
        z_addr = 32'(i*4);
      end else begin
        z_we = 1'($urandom_range(0, 1));
        z_f3 = 3'($urandom_range(0, 7));
        z_addr = 32'($urandom_range(0, 7)*4);
        if ($urandom_range(0, 3) == 0) z_addr = z_addr + 32'($urandom_range(1, 3));
        if ($urandom_range(0, 7) == 0) z_addr = 32'(DEPTH*4);
      end
      z_wdata = $urandom;
      for (k = 0; k < 10; k++) begin
        if (z_ready) break;
        @(negedge clk);
      end
      chk("z_ready_wait", z_ready, 1);
      acc = cyc + 1;
      if (i > 0) chk("z_spacing", acc - prev, 2);
      prev = acc;
      apply(1'b1, z_we, z_f3, z_addr, z_wdata, cyc + 1 + WZ);
      @(posedge clk);
      @(negedge clk);
    end
    z_valid = 1'b0;

    repeat (10) @(negedge clk);
    chk("a_queue_drained", qa.size(), 0);
    chk("z_queue_drained", qz.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
